mul_pipe_ctrl: RTL and testbench
================================

# mul_pipe_ctrl

Pipeline controller for the shared Booth/Wallace-tree multiplier datapath in the EXE→WB path. It accepts multiply requests from the execute stage with a valid/ready handshake and drives the load enables of the datapath's pipeline registers. It tracks the operation and destination tag of each in-flight multiply and presents completed results to writeback with backpressure. An exception or branch flush cancels all in-flight work.

## Interface
Parameters:
- STAGES, 2: number of datapath register stages, from partial-product capture through the final adder; legal range 1..4.
- TAG_W, 5: width of the destination tag carried alongside each operation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  execute stage presents a multiply.
- req_ready  out  1  controller accepts this cycle.
- req_op  in  2  operation: 00 MUL (low word), 01 MULH (signed high), 10 MULHU (unsigned high), 11 reserved, executed as MUL.
- req_tag  in  TAG_W  destination tag.
- flush  in  1  cancels all in-flight and offered operations.
- stage_en  out  STAGES  bit k loads datapath stage-k registers this cycle.
- dp_signed  out  1  operand sign-extension select for the Booth encoder; equals 1 when req_op==01, else 0. Combinational.
- dp_hi_sel  out  1  result-word select for the last stage: 1 for MULH/MULHU held in the last stage.
- resp_valid  out  1  last stage holds a completed result.
- resp_ready  in  1  writeback consumes the result.
- resp_op  out  2  op of the last-stage entry.
- resp_tag  out  TAG_W  tag of the last-stage entry.
- busy  out  1  any stage valid.
- perf_ops  out  32  completed-operation count (see Configuration).
- perf_stalls  out  32  backpressure-stall cycle count (see Configuration).

## Operation
- Per-stage state: a valid bit v[k], op[k] and tag[k] for k = 0..STAGES-1. Stage STAGES-1 is the output stage.
- Advance rule:
  - The output stage drains when resp_valid && resp_ready.
  - Stage k may load when it is empty or draining. Stage k is draining when it is the output stage and drains, or when stage k+1 loads from it.
  - Stages k ≥ 1 load from stage k-1 only if v[k-1]==1.
- req_ready = !flush && (stage 0 empty or draining). Acceptance is req_valid && req_ready.
- stage_en[0] = acceptance. stage_en[k] for k ≥ 1 = (stage k loads from stage k-1).
- A stage whose predecessor advances out while it receives nothing clears its valid bit. A stalled stage holds its valid bit, op and tag, and keeps stage_en low.
- resp_valid = v[STAGES-1]. resp_op, resp_tag and dp_hi_sel are decoded from the output-stage registers.
- Flush has priority over everything:
  - All v[k] are cleared at the next edge.
  - No acceptance occurs in the flush cycle.
  - A result draining in the flush cycle is still counted as consumed.
  - op and tag registers are don't-care once invalid.
- busy = OR of v[k].

## Timing
- Reset values: all v[k]=0, so resp_valid=0 and busy=0. req_ready=1 (unless flush is asserted). stage_en=0, dp_hi_sel=0, resp_op=0, resp_tag=0, perf counters=0.
- Latency: an operation accepted in cycle t shows resp_valid=1 in cycle t+STAGES.
- Throughput: one operation per cycle with resp_ready held high.
- Full-pipeline backpressure: with resp_ready=0 and all stages valid, req_ready=0.
  - On release, one entry drains per cycle.
  - req_ready rises combinationally in the same cycle resp_ready rises, so there are no bubbles.
- Simultaneous accept and drain in a full pipeline is legal and keeps occupancy constant.
- Reset asserted mid-operation clears all state immediately. No response is produced for the discarded operations.

## Configuration
- MUL_PIPE_CTRL_PERF_EN defined:
  - perf_ops increments on every drain.
  - perf_stalls increments on every cycle with resp_valid && !resp_ready.
  - Both are 32-bit, wrap modulo 2^32, and are cleared only by reset. Flush does not clear them.
- Macro undefined: the counters are not built, and perf_ops and perf_stalls are tied to 0.

## Test plan
STAGES=2 unless stated.
- Reset, then a single MULH request with tag 7 accepted in cycle 0, with resp_ready=1:
  - stage_en=01 in cycle 0 and 10 in cycle 1.
  - resp_valid=1 in cycle 2 with resp_op=01, resp_tag=7, dp_hi_sel=1.
  - busy is 0 in cycle 3.
- Back-to-back tags 1, 2, 3, 4 with resp_ready=1: responses appear in cycles 2–5 with tags 1–4 in order, and req_ready stays 1 throughout.
- Fill with tags 1 and 2 and hold resp_ready=0 for 5 cycles:
  - req_ready=0, stage_en=00 and resp_tag stays 1 during the hold.
  - With PERF_EN, perf_stalls=5.
  - On release, tags 1 and 2 drain in consecutive cycles.
- Flush asserted with 2 entries in flight and req_valid=1:
  - req_ready=0 in the flush cycle.
  - The next cycle has busy=0 and resp_valid=0, and no response for the flushed tags ever appears.
- Pulse resetn low mid-stream with 2 entries valid: resp_valid drops asynchronously, and after release the state equals the reset values.
- STAGES=1, req_op=11, tag 3: the response arrives in cycle 1 with dp_hi_sel=0.

Source files
------------

// File: rtl/mul_pipe_ctrl.sv
// Purpose : pipeline controller for the shared Booth/Wallace multiplier (EXE->WB); tracks op/tag per datapath stage.
// Latency : an operation accepted in cycle t is presented to writeback in cycle t+STAGES.
// Backpr. : stages compress behind a stalled output stage; req_ready drops only when every stage is full and not draining.
//
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   req_valid/req_ready/req_op/req_tag   request handshake from execute
//   flush                            cancels every in-flight and offered operation
//   stage_en[STAGES]                 per-stage load enables for the datapath registers
//   dp_signed                        Booth sign-extension select (combinational from req_op)
//   dp_hi_sel                        high-word select for the output stage
//   resp_valid/resp_ready/resp_op/resp_tag   result handshake to writeback
//   busy                             any stage valid
//   perf_ops, perf_stalls            performance counters
//
// Optional feature: define MUL_PIPE_CTRL_PERF_EN to build the performance counters;
// otherwise perf_ops and perf_stalls are tied to zero.
module mul_pipe_ctrl #(
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic              flush,
    output logic [STAGES-1:0] stage_en,
    output logic              dp_signed,
    output logic              dp_hi_sel,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [1:0]        resp_op,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              busy,
    output logic [31:0]       perf_ops,
    output logic [31:0]       perf_stalls
);

    logic [STAGES-1:0] v_q, v_d;
    logic [1:0]        op_q  [STAGES];
    logic [1:0]        op_d  [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [TAG_W-1:0]  tag_d [STAGES];

    logic [STAGES-1:0] ld;      // ld[k]: stage k loads this cycle (ld[0] is acceptance)
    logic [STAGES-1:0] drn;     // drn[k]: stage k's entry leaves this cycle
    logic              drain;
    logic              accept;

    // Load/drain decisions ripple from the output stage back to stage 0,
    // so a draining output frees the whole compressed chain in one cycle.
    always_comb begin
        drain = v_q[STAGES-1] && resp_ready;
        drn   = '0;
        ld    = '0;
        drn[STAGES-1] = drain;
        for (int k = STAGES - 1; k >= 1; k--) begin
            ld[k]     = (!v_q[k] || drn[k]) && v_q[k-1];
            drn[k-1]  = ld[k];
        end
        req_ready = !flush && (!v_q[0] || drn[0]);
        accept    = req_valid && req_ready;
        ld[0]     = accept;
    end

    always_comb begin
        v_d   = v_q;
        op_d  = op_q;
        tag_d = tag_q;
        if (ld[0]) begin
            v_d[0]   = 1'b1;
            op_d[0]  = req_op;
            tag_d[0] = req_tag;
        end else if (drn[0]) begin
            v_d[0] = 1'b0;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (ld[k]) begin
                v_d[k]   = 1'b1;
                op_d[k]  = op_q[k-1];
                tag_d[k] = tag_q[k-1];
            end else if (drn[k]) begin
                v_d[k] = 1'b0;
            end
        end
        // op/tag may still shift during a flush; they are don't-care once invalid.
        if (flush) begin
            v_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                op_q[k]  <= 2'b00;
                tag_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int k = 0; k < STAGES; k++) begin
                op_q[k]  <= op_d[k];
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign stage_en   = ld;
    assign dp_signed  = (req_op == 2'b01);
    assign resp_valid = v_q[STAGES-1];
    assign resp_op    = op_q[STAGES-1];
    assign resp_tag   = tag_q[STAGES-1];
    // Reserved op 11 runs as MUL, so only MULH/MULHU select the high word.
    assign dp_hi_sel  = v_q[STAGES-1] &&
                        ((op_q[STAGES-1] == 2'b01) || (op_q[STAGES-1] == 2'b10));
    assign busy       = |v_q;

`ifdef MUL_PIPE_CTRL_PERF_EN
    logic [31:0] perf_ops_q, perf_ops_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;

    // A drain during a flush cycle still counts as a completed operation.
    always_comb begin
        perf_ops_d    = perf_ops_q + {31'd0, drain};
        perf_stalls_d = perf_stalls_q + {31'd0, (v_q[STAGES-1] && !resp_ready)};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_ops_q    <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_ops_q    <= perf_ops_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign perf_ops    = perf_ops_q;
    assign perf_stalls = perf_stalls_q;
`else
    assign perf_ops    = '0;
    assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_mul_pipe_ctrl.sv
module tb_mul_pipe_ctrl;
    localparam int TAG_W = 5;
`ifdef MUL_PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    // Main instance, STAGES=2
    logic             req_valid = 1'b0, req_ready, flush = 1'b0, resp_ready = 1'b0;
    logic             dp_signed, dp_hi_sel, resp_valid, busy;
    logic [1:0]       req_op = 2'b00, resp_op, stage_en;
    logic [TAG_W-1:0] req_tag = '0, resp_tag;
    logic [31:0]      perf_ops, perf_stalls;

    // Second instance, STAGES=1
    logic             b_req_valid = 1'b0, b_req_ready, b_flush = 1'b0, b_resp_ready = 1'b0;
    logic             b_dp_signed, b_dp_hi_sel, b_resp_valid, b_busy;
    logic [1:0]       b_req_op = 2'b00, b_resp_op;
    logic [0:0]       b_stage_en;
    logic [TAG_W-1:0] b_req_tag = '0, b_resp_tag;
    logic [31:0]      b_perf_ops, b_perf_stalls;

    int tests = 0;
    int fails = 0;

    mul_pipe_ctrl #(.STAGES(2), .TAG_W(TAG_W)) u_dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_tag(req_tag),
        .flush(flush), .stage_en(stage_en), .dp_signed(dp_signed), .dp_hi_sel(dp_hi_sel),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_op(resp_op), .resp_tag(resp_tag),
        .busy(busy), .perf_ops(perf_ops), .perf_stalls(perf_stalls)
    );

    mul_pipe_ctrl #(.STAGES(1), .TAG_W(TAG_W)) u_dut1 (
        .clk(clk), .resetn(resetn),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_op(b_req_op), .req_tag(b_req_tag),
        .flush(b_flush), .stage_en(b_stage_en), .dp_signed(b_dp_signed), .dp_hi_sel(b_dp_hi_sel),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_op(b_resp_op), .resp_tag(b_resp_tag),
        .busy(b_busy), .perf_ops(b_perf_ops), .perf_stalls(b_perf_stalls)
    );

    task automatic drive(input logic rv, input logic [1:0] op, input logic [TAG_W-1:0] tag,
                         input logic rr, input logic fl);
        req_valid  = rv;
        req_op     = op;
        req_tag    = tag;
        resp_ready = rr;
        flush      = fl;
    endtask

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        drive(1'b0, 2'b00, '0, 1'b0, 1'b0);
        b_req_valid = 1'b0; b_req_op = 2'b00; b_req_tag = '0; b_resp_ready = 1'b0; b_flush = 1'b0;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic test_reset;
        drive(1'b0, 2'b00, '0, 1'b0, 1'b0);
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #1;
        tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        tests++; if (stage_en !== 2'b00) begin fails++; $display("FAIL reset_stage_en got %b want 00", stage_en); end
        tests++; if (dp_hi_sel !== 1'b0) begin fails++; $display("FAIL reset_dp_hi_sel got %b want 0", dp_hi_sel); end
        tests++; if (resp_op !== 2'b00 || resp_tag !== '0) begin fails++; $display("FAIL reset_resp_op_tag got %b/%0d want 00/0", resp_op, resp_tag); end
        tests++; if (perf_ops !== 32'd0 || perf_stalls !== 32'd0) begin fails++; $display("FAIL reset_perf got %0d/%0d want 0/0", perf_ops, perf_stalls); end
        flush = 1'b1;
        #1;
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_flush_req_ready got %b want 0", req_ready); end
        flush = 1'b0;
    endtask

    task automatic test_single_mulh;
        do_reset();
        drive(1'b1, 2'b01, 5'd7, 1'b1, 1'b0);
        @(negedge clk);
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL mulh_c0_req_ready got %b want 1", req_ready); end
        tests++; if (stage_en !== 2'b01) begin fails++; $display("FAIL mulh_c0_stage_en got %b want 01", stage_en); end
        tests++; if (dp_signed !== 1'b1) begin fails++; $display("FAIL mulh_c0_dp_signed got %b want 1", dp_signed); end
        next_cyc();
        drive(1'b0, 2'b00, '0, 1'b1, 1'b0);
        @(negedge clk);
        tests++; if (stage_en !== 2'b10) begin fails++; $display("FAIL mulh_c1_stage_en got %b want 10", stage_en); end
        tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL mulh_c1_resp_valid got %b want 0", resp_valid); end
        next_cyc();
        @(negedge clk);
        tests++; if (resp_valid !== 1'b1) begin fails++; $display("FAIL mulh_c2_resp_valid got %b want 1", resp_valid); end
        tests++; if (resp_op !== 2'b01 || resp_tag !== 5'd7) begin fails++; $display("FAIL mulh_c2_op_tag got %b/%0d want 01/7", resp_op, resp_tag); end
        tests++; if (dp_hi_sel !== 1'b1) begin fails++; $display("FAIL mulh_c2_dp_hi_sel got %b want 1", dp_hi_sel); end
        next_cyc();
        @(negedge clk);
        tests++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin fails++; $display("FAIL mulh_c3_idle busy=%b valid=%b want 0/0", busy, resp_valid); end
        next_cyc();
    endtask

    task automatic test_back_to_back;
        logic exp_v;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c < 4) drive(1'b1, 2'(c), 5'(c + 1), 1'b1, 1'b0);
            else       drive(1'b0, 2'b00, '0, 1'b1, 1'b0);
            @(negedge clk);
            exp_v = (c >= 2 && c <= 5);
            if (c < 4) begin
                tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_req_ready c%0d got %b want 1", c, req_ready); end
            end
            tests++; if (resp_valid !== exp_v) begin fails++; $display("FAIL b2b_resp_valid c%0d got %b want %b", c, resp_valid, exp_v); end
            if (exp_v) begin
                tests++; if (resp_tag !== 5'(c - 1)) begin fails++; $display("FAIL b2b_resp_tag c%0d got %0d want %0d", c, resp_tag, c - 1); end
            end
            next_cyc();
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            if (c == 0)      drive(1'b1, 2'b00, 5'd1, 1'b1, 1'b0);
            else if (c == 1) drive(1'b1, 2'b00, 5'd2, 1'b1, 1'b0);
            else if (c < 7)  drive(1'b1, 2'b00, 5'd9, 1'b0, 1'b0);
            else if (c == 7) drive(1'b1, 2'b00, 5'd3, 1'b1, 1'b0);
            else             drive(1'b0, 2'b00, '0, 1'b1, 1'b0);
            @(negedge clk);
            if (c >= 2 && c < 7) begin
                tests++; if (req_ready !== 1'b0 || stage_en !== 2'b00) begin fails++; $display("FAIL bp_hold c%0d rdy=%b en=%b want 0/00", c, req_ready, stage_en); end
                tests++; if (resp_valid !== 1'b1 || resp_tag !== 5'd1) begin fails++; $display("FAIL bp_hold_tag c%0d valid=%b tag=%0d want 1/1", c, resp_valid, resp_tag); end
            end else if (c == 7) begin
                tests++; if (req_ready !== 1'b1 || stage_en !== 2'b11) begin fails++; $display("FAIL bp_release rdy=%b en=%b want 1/11", req_ready, stage_en); end
                tests++; if (resp_valid !== 1'b1 || resp_tag !== 5'd1) begin fails++; $display("FAIL bp_release_tag valid=%b tag=%0d want 1/1", resp_valid, resp_tag); end
            end else if (c == 8 || c == 9) begin
                tests++; if (resp_valid !== 1'b1 || resp_tag !== 5'(c - 6)) begin fails++; $display("FAIL bp_drain c%0d valid=%b tag=%0d want 1/%0d", c, resp_valid, resp_tag, c - 6); end
            end else if (c == 10) begin
                tests++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL bp_empty valid=%b busy=%b want 0/0", resp_valid, busy); end
            end
            next_cyc();
        end
        tests++; if (perf_stalls !== (PERF ? 32'd5 : 32'd0)) begin fails++; $display("FAIL bp_perf_stalls got %0d want %0d", perf_stalls, PERF ? 5 : 0); end
        tests++; if (perf_ops !== (PERF ? 32'd3 : 32'd0)) begin fails++; $display("FAIL bp_perf_ops got %0d want %0d", perf_ops, PERF ? 3 : 0); end
    endtask

    task automatic test_flush;
        do_reset();
        drive(1'b1, 2'b01, 5'd5, 1'b0, 1'b0); next_cyc();
        drive(1'b1, 2'b10, 5'd6, 1'b0, 1'b0); next_cyc();
        drive(1'b1, 2'b00, 5'd8, 1'b1, 1'b1);
        @(negedge clk);
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL flush_req_ready got %b want 0", req_ready); end
        tests++; if (resp_valid !== 1'b1 || resp_tag !== 5'd5) begin fails++; $display("FAIL flush_drain valid=%b tag=%0d want 1/5", resp_valid, resp_tag); end
        next_cyc();
        drive(1'b0, 2'b00, '0, 1'b1, 1'b0);
        @(negedge clk);
        tests++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin fails++; $display("FAIL flush_after busy=%b valid=%b want 0/0", busy, resp_valid); end
        for (int c = 0; c < 6; c++) begin
            next_cyc();
            @(negedge clk);
            tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL flush_ghost c%0d valid=%b tag=%0d want no response", c, resp_valid, resp_tag); end
        end
        tests++; if (perf_ops !== (PERF ? 32'd1 : 32'd0) || perf_stalls !== 32'd0) begin fails++; $display("FAIL flush_perf got %0d/%0d want %0d/0", perf_ops, perf_stalls, PERF ? 1 : 0); end
        next_cyc();
    endtask

    task automatic test_async_reset;
        do_reset();
        drive(1'b1, 2'b10, 5'd1, 1'b0, 1'b0); next_cyc();
        drive(1'b1, 2'b10, 5'd2, 1'b0, 1'b0); next_cyc();
        drive(1'b0, 2'b00, '0, 1'b0, 1'b0);
        @(negedge clk);
        tests++; if (resp_valid !== 1'b1 || busy !== 1'b1 || dp_hi_sel !== 1'b1) begin fails++; $display("FAIL arst_pre valid=%b busy=%b hi=%b want 1/1/1", resp_valid, busy, dp_hi_sel); end
        #1 resetn = 1'b0;
        #1;
        tests++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL arst_immediate valid=%b busy=%b want 0/0", resp_valid, busy); end
        @(posedge clk);
        #1 resetn = 1'b1;
        #1;
        tests++; if (req_ready !== 1'b1 || stage_en !== 2'b00 || dp_hi_sel !== 1'b0) begin fails++; $display("FAIL arst_state rdy=%b en=%b hi=%b want 1/00/0", req_ready, stage_en, dp_hi_sel); end
        tests++; if (resp_op !== 2'b00 || resp_tag !== '0 || perf_ops !== 32'd0 || perf_stalls !== 32'd0) begin fails++; $display("FAIL arst_regs op=%b tag=%0d perf=%0d/%0d want zeros", resp_op, resp_tag, perf_ops, perf_stalls); end
        resp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL arst_ghost c%0d valid=%b want 0", c, resp_valid); end
            next_cyc();
        end
    endtask

    task automatic test_stages1;
        do_reset();
        b_req_valid = 1'b1; b_req_op = 2'b11; b_req_tag = 5'd3; b_resp_ready = 1'b1;
        @(negedge clk);
        tests++; if (b_req_ready !== 1'b1 || b_stage_en !== 1'b1) begin fails++; $display("FAIL s1_c0 rdy=%b en=%b want 1/1", b_req_ready, b_stage_en); end
        tests++; if (b_resp_valid !== 1'b0 || b_dp_signed !== 1'b0) begin fails++; $display("FAIL s1_c0_out valid=%b signed=%b want 0/0", b_resp_valid, b_dp_signed); end
        next_cyc();
        b_req_valid = 1'b0; b_req_op = 2'b00; b_req_tag = '0;
        @(negedge clk);
        tests++; if (b_resp_valid !== 1'b1 || b_resp_tag !== 5'd3 || b_busy !== 1'b1) begin fails++; $display("FAIL s1_c1 valid=%b tag=%0d busy=%b want 1/3/1", b_resp_valid, b_resp_tag, b_busy); end
        tests++; if (b_dp_hi_sel !== 1'b0 || b_resp_op !== 2'b11) begin fails++; $display("FAIL s1_c1_op hi=%b op=%b want 0/11", b_dp_hi_sel, b_resp_op); end
        next_cyc();
        @(negedge clk);
        tests++; if (b_resp_valid !== 1'b0 || b_busy !== 1'b0) begin fails++; $display("FAIL s1_c2 valid=%b busy=%b want 0/0", b_resp_valid, b_busy); end
        tests++; if (b_perf_ops !== (PERF ? 32'd1 : 32'd0) || b_perf_stalls !== 32'd0) begin fails++; $display("FAIL s1_perf got %0d/%0d want %0d/0", b_perf_ops, b_perf_stalls, PERF ? 1 : 0); end
        next_cyc();
    endtask

    // Reference: in-flight ops form an ordered queue; the head becomes visible
    // STAGES cycles after acceptance, but never before the cycle after the previous
    // head drained. Acceptance needs spare capacity or a drain in the same cycle.
    task automatic test_random;
        int               m_acc[$];
        logic [1:0]       m_op[$];
        logic [TAG_W-1:0] m_tag[$];
        int               last_drain;
        int               vis;
        int unsigned      m_ops, m_stalls;
        logic             exp_v, exp_drn, exp_rdy, exp_acc, exp_hi, bad;
        do_reset();
        last_drain = -100;
        m_ops = 0;
        m_stalls = 0;
        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(3) != 0), 2'($urandom_range(3)), TAG_W'($urandom),
                  ($urandom_range(2) != 0), ($urandom_range(24) == 0));
            @(negedge clk);
            exp_v = 1'b0;
            if (m_acc.size() > 0) begin
                vis = m_acc[0] + 2;
                if (last_drain + 1 > vis) vis = last_drain + 1;
                exp_v = (c >= vis);
            end
            exp_drn = exp_v && resp_ready;
            exp_rdy = !flush && (m_acc.size() < 2 || exp_drn);
            exp_acc = req_valid && exp_rdy;
            exp_hi  = exp_v && (m_op[0] == 2'b01 || m_op[0] == 2'b10);
            bad = (req_ready !== exp_rdy) || (resp_valid !== exp_v) || (busy !== (m_acc.size() > 0)) ||
                  (stage_en[0] !== exp_acc) || (dp_signed !== (req_op == 2'b01)) || (dp_hi_sel !== exp_hi) ||
                  (perf_ops !== (PERF ? m_ops : 0)) || (perf_stalls !== (PERF ? m_stalls : 0));
            if (exp_v) bad = bad || (resp_tag !== m_tag[0]) || (resp_op !== m_op[0]);
            tests++;
            if (bad) begin
                fails++;
                $display("FAIL rand c%0d got rdy=%b v=%b busy=%b en0=%b hi=%b tag=%0d perf=%0d/%0d want rdy=%b v=%b busy=%b en0=%b hi=%b tag=%0d perf=%0d/%0d",
                         c, req_ready, resp_valid, busy, stage_en[0], dp_hi_sel, resp_tag, perf_ops, perf_stalls,
                         exp_rdy, exp_v, (m_acc.size() > 0), exp_acc, exp_hi, (exp_v ? m_tag[0] : '0),
                         PERF ? m_ops : 0, PERF ? m_stalls : 0);
            end
            if (exp_v && !resp_ready) m_stalls++;
            if (exp_drn) begin
                void'(m_acc.pop_front()); void'(m_op.pop_front()); void'(m_tag.pop_front());
                last_drain = c;
                m_ops++;
            end
            if (flush) begin
                m_acc.delete(); m_op.delete(); m_tag.delete();
            end else if (exp_acc) begin
                m_acc.push_back(c); m_op.push_back(req_op); m_tag.push_back(req_tag);
            end
            next_cyc();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_mulh();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_stages1();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
